// File: rtl/keypad_pkg.sv
// Shared keypad constants: key indices (row*4+col), ALU operator codes and display codes.
// Helper functions classify key indices and encode a one-hot snapshot.
package keypad_pkg;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_BKSP = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_SIGN = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_PLUS  = 3'd1;
  localparam logic [2:0] OP_MINUS = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;

  localparam logic [31:0] FND_BLANK = 32'h00CC_0000;
  localparam logic [31:0] FND_ERR   = 32'h00EE_0000;

  typedef enum logic [1:0] {
    DEB_IDLE    = 2'd0,
    DEB_PRESS   = 2'd1,
    DEB_HELD    = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_t;

  function automatic logic key_is_digit(input logic [3:0] idx);
    case (idx)
      KEY_A, KEY_B, KEY_C, KEY_D, KEY_BKSP, KEY_SIGN: return 1'b0;
      default:                                        return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] idx);
    case (idx)
      KEY_1:   return 4'd1;
      KEY_2:   return 4'd2;
      KEY_3:   return 4'd3;
      KEY_4:   return 4'd4;
      KEY_5:   return 4'd5;
      KEY_6:   return 4'd6;
      KEY_7:   return 4'd7;
      KEY_8:   return 4'd8;
      KEY_9:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] onehot_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Drives one keypad column at a time, assembles a 16-bit press snapshot per sweep
// and debounces it into a one-clock key strobe with the accepted key index.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_stb,
  output logic [3:0] key_idx
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_r;
  logic [15:0]      snap_r;
  logic [15:0]      snap_full_s;
  logic             dwell_end_s;
  logic             sweep_s;
  logic             single_s;
  logic             match_s;
  logic             zero_s;

  deb_state_t       state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [3:0]       key_r, key_n;
  logic             stb_r, stb_n;

  assign dwell_end_s = (div_r == DIV_W'(SCAN_DIV - 1));
  assign sweep_s     = dwell_end_s && (col_r == 2'd3);
  assign single_s    = (snap_full_s != 16'd0) && ((snap_full_s & (snap_full_s - 16'd1)) == 16'd0);
  assign match_s     = (snap_full_s == (16'd1 << key_r));
  assign zero_s      = (snap_full_s == 16'd0);
  assign key_stb     = stb_r;
  assign key_idx     = key_r;

  // Merge the rows seen on the current column into the sweep snapshot.
  always_comb begin
    snap_full_s = snap_r;
    for (int r = 0; r < 4; r++) begin
      snap_full_s[r*4 + int'(col_r)] = ~key_row[r];
    end
  end

  // Column dwell counter, column drive and snapshot capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= '0;
      col_r   <= 2'd0;
      key_col <= 4'b1110;
      snap_r  <= 16'd0;
    end else if (dwell_end_s) begin
      div_r   <= '0;
      col_r   <= col_r + 2'd1;
      key_col <= ~(4'b0001 << (col_r + 2'd1));
      snap_r  <= snap_full_s;
    end else begin
      div_r   <= div_r + DIV_W'(1);
    end
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DEB_IDLE;
      cnt_r   <= '0;
      key_r   <= 4'd0;
      stb_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      key_r   <= key_n;
      stb_r   <= stb_n;
    end
  end

  // Debounce next state, evaluated only when a sweep completes.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    key_n   = key_r;
    stb_n   = 1'b0;
    if (sweep_s) begin
      case (state_r)
        DEB_IDLE: begin
          if (single_s) begin
            key_n = onehot_index(snap_full_s);
            cnt_n = CNT_W'(1);
            if (DEBOUNCE_SCANS <= 1) begin
              stb_n   = 1'b1;
              state_n = DEB_HELD;
            end else begin
              state_n = DEB_PRESS;
            end
          end else begin
            state_n = DEB_IDLE;
          end
        end
        DEB_PRESS: begin
          if (!match_s) begin
            state_n = DEB_IDLE;
          end else if (cnt_r + CNT_W'(1) >= CNT_W'(DEBOUNCE_SCANS)) begin
            stb_n   = 1'b1;
            state_n = DEB_HELD;
          end else begin
            cnt_n   = cnt_r + CNT_W'(1);
          end
        end
        DEB_HELD: begin
          if (zero_s) begin
            cnt_n   = CNT_W'(1);
            state_n = (DEBOUNCE_SCANS <= 1) ? DEB_IDLE : DEB_RELEASE;
          end else begin
            state_n = DEB_HELD;
          end
        end
        DEB_RELEASE: begin
          if (!zero_s) begin
            state_n = DEB_HELD;
          end else if (cnt_r + CNT_W'(1) >= CNT_W'(DEBOUNCE_SCANS)) begin
            state_n = DEB_IDLE;
          end else begin
            cnt_n   = cnt_r + CNT_W'(1);
          end
        end
        default: state_n = DEB_IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad numeric entry: builds a signed decimal operand and emits operator events.
// Optional KEYPAD_ECHO_EN adds key_code/key_stb echo ports for every accepted press.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 5
) (
  input  logic        key_clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic [31:0] key_value,
  output logic [31:0] num_out,
  output logic [2:0]  op_code,
  output logic        op_valid
`ifdef KEYPAD_ECHO_EN
  ,
  output logic [3:0]  key_code,
  output logic        key_stb
`endif
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic        stb_s;
  logic [3:0]  idx_s;
  logic [3:0]  digit_s;

  logic [16:0]   mag_r, mag_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic          sign_r, sign_n;
  logic          empty_r, empty_n;
  logic          op_fire_s;
  logic [2:0]    op_n;
  logic [31:0]   num_n;

  function automatic logic [31:0] signed_value(input logic [16:0] mag, input logic sign);
    logic [31:0] ext;
    ext = {15'd0, mag};
    return sign ? (32'd0 - ext) : ext;
  endfunction

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk     (key_clk),
    .rst     (rst),
    .key_row (key_row),
    .key_col (key_col),
    .key_stb (stb_s),
    .key_idx (idx_s)
  );

  assign digit_s = key_digit(idx_s);

  // Entry update for the accepted key; operator keys snapshot the value and clear the entry.
  always_comb begin
    mag_n     = mag_r;
    cnt_n     = cnt_r;
    sign_n    = sign_r;
    empty_n   = empty_r;
    op_fire_s = 1'b0;
    op_n      = op_code;
    num_n     = num_out;
    if (stb_s) begin
      if (key_is_digit(idx_s)) begin
        if (cnt_r != CW'(MAX_DIGITS)) begin
          mag_n   = mag_r * 17'd10 + {13'd0, digit_s};
          cnt_n   = (mag_r == 17'd0 && digit_s == 4'd0) ? cnt_r : cnt_r + CW'(1);
          empty_n = 1'b0;
        end else begin
          mag_n   = mag_r;
        end
      end else begin
        case (idx_s)
          KEY_BKSP: begin
            mag_n   = mag_r / 17'd10;
            cnt_n   = (cnt_r == '0) ? '0 : cnt_r - CW'(1);
            empty_n = (cnt_n == '0);
            sign_n  = (mag_n == 17'd0) ? 1'b0 : sign_r;
          end
          KEY_SIGN: begin
            sign_n = (mag_r != 17'd0) ? ~sign_r : sign_r;
          end
          KEY_A, KEY_B, KEY_C, KEY_D: begin
            num_n     = empty_r ? 32'd0 : signed_value(mag_r, sign_r);
            op_fire_s = 1'b1;
            case (idx_s)
              KEY_A:   op_n = OP_PLUS;
              KEY_B:   op_n = OP_MINUS;
              KEY_C:   op_n = OP_MULT;
              default: op_n = OP_DIV;
            endcase
            mag_n   = 17'd0;
            cnt_n   = '0;
            sign_n  = 1'b0;
            empty_n = 1'b1;
          end
          default: mag_n = mag_r;
        endcase
      end
    end else begin
      mag_n = mag_r;
    end
  end

  // Entry state and registered outputs.
  always_ff @(posedge key_clk) begin
    if (rst) begin
      mag_r     <= 17'd0;
      cnt_r     <= '0;
      sign_r    <= 1'b0;
      empty_r   <= 1'b1;
      key_value <= FND_BLANK;
      num_out   <= 32'd0;
      op_code   <= OP_NONE;
      op_valid  <= 1'b0;
    end else begin
      mag_r     <= mag_n;
      cnt_r     <= cnt_n;
      sign_r    <= sign_n;
      empty_r   <= empty_n;
      key_value <= empty_n ? FND_BLANK : signed_value(mag_n, sign_n);
      num_out   <= num_n;
      op_code   <= op_n;
      op_valid  <= op_fire_s;
    end
  end

`ifdef KEYPAD_ECHO_EN
  // Echo of every accepted press, aligned with the entry update.
  always_ff @(posedge key_clk) begin
    if (rst) begin
      key_code <= 4'd0;
      key_stb  <= 1'b0;
    end else begin
      key_code <= stb_s ? idx_s : key_code;
      key_stb  <= stb_s;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a behavioural entry model queues expected display
// values and operator events; a monitor pops operator events on op_valid.
module tb_keypad_entry;

  localparam int SWEEP = 16;           // SCAN_DIV=4 clocks x 4 columns
  localparam int HOLD  = 3 * SWEEP;

  // Bench-side key indices (row*4+col)
  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6, KB = 7;
  localparam int K7 = 8, K8 = 9, K9 = 10, KC = 11, KSTAR = 12, K0 = 13, KHASH = 14, KD = 15;

  logic        key_clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [31:0] key_value;
  logic [31:0] num_out;
  logic [2:0]  op_code;
  logic        op_valid;

  logic [15:0] pressed = 16'd0;

  int n_checks = 0;
  int n_pass   = 0;
  int ops_seen = 0;
  int ops_exp  = 0;

  logic [31:0] kv_q[$];
  logic [31:0] num_q[$];
  logic [31:0] op_q[$];

  // Entry model state
  int m_mag   = 0;
  int m_cnt   = 0;
  bit m_sign  = 1'b0;
  bit m_empty = 1'b1;
  int dig_tab[16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .MAX_DIGITS(5)) dut (
    .key_clk   (key_clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_value (key_value),
    .num_out   (num_out),
    .op_code   (op_code),
    .op_valid  (op_valid)
  );

  always #5 key_clk = ~key_clk;

  // Resistive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_kv();
    logic [31:0] v;
    v = 32'(m_mag);
    if (m_empty) return 32'h00CC_0000;
    return m_sign ? (32'd0 - v) : v;
  endfunction

  function automatic void model_reset();
    m_mag = 0; m_cnt = 0; m_sign = 1'b0; m_empty = 1'b1;
  endfunction

  function automatic void model_key(input int k);
    int d;
    d = dig_tab[k];
    if (d >= 0) begin
      if (m_cnt != 5) begin
        if (!(m_mag == 0 && d == 0)) m_cnt++;
        m_mag   = m_mag * 10 + d;
        m_empty = 1'b0;
      end
    end else if (k == KSTAR) begin
      m_mag = m_mag / 10;
      if (m_cnt > 0) m_cnt--;
      if (m_cnt == 0) m_empty = 1'b1;
      if (m_mag == 0) m_sign = 1'b0;
    end else if (k == KHASH) begin
      if (m_mag != 0) m_sign = !m_sign;
    end else begin
      num_q.push_back(m_empty ? 32'd0 : model_kv());
      op_q.push_back((k == KA) ? 32'd1 : (k == KB) ? 32'd2 : (k == KC) ? 32'd3 : 32'd4);
      ops_exp++;
      model_reset();
    end
  endfunction

  // Hold one key for three sweeps, release for three, then compare the display.
  task automatic press(input int k, input string tag);
    model_key(k);
    kv_q.push_back(model_kv());
    pressed = 16'd1 << k;
    repeat (HOLD) @(posedge key_clk);
    pressed = 16'd0;
    repeat (HOLD) @(posedge key_clk);
    @(negedge key_clk);
    check_eq(tag, key_value, kv_q.pop_front());
  endtask

  // Operator event monitor.
  always @(negedge key_clk) begin
    if (!rst && op_valid) begin
      ops_seen++;
      if (num_q.size() == 0) begin
        check_eq("op_unexpected", {31'd0, op_valid}, 32'd0);
      end else begin
        check_eq("op_num", num_out, num_q.pop_front());
        check_eq("op_code", {29'd0, op_code}, op_q.pop_front());
      end
    end
  end

  logic [3:0] col_tab[4];

  initial begin
    col_tab[0] = 4'b1101; col_tab[1] = 4'b1011; col_tab[2] = 4'b0111; col_tab[3] = 4'b1110;
    rst = 1'b1;
    repeat (2) @(posedge key_clk);
    @(negedge key_clk);
    check_eq("rst_key_col", {28'd0, key_col}, 32'h0000_000E);
    check_eq("rst_key_value", key_value, 32'h00CC_0000);
    check_eq("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check_eq("rst_num_out", num_out, 32'd0);
    check_eq("rst_op_code", {29'd0, op_code}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge key_clk);
      @(negedge key_clk);
      check_eq($sformatf("col_rot%0d", i), {28'd0, key_col}, {28'd0, col_tab[i]});
    end

    press(K1, "kv_1");
    press(K2, "kv_12");
    press(K3, "kv_123");
    check_eq("kv_123_lit", key_value, 32'h0000_007B);
    press(KHASH, "kv_neg123");
    check_eq("kv_neg123_lit", key_value, 32'hFFFF_FF85);
    press(KA, "kv_after_A");
    check_eq("num_held_A", num_out, 32'hFFFF_FF85);
    check_eq("op_held_A", {29'd0, op_code}, 32'd1);

    press(K1, "kv_d1"); press(K2, "kv_d2"); press(K3, "kv_d3");
    press(K4, "kv_d4"); press(K5, "kv_d5"); press(K6, "kv_d6_ignored");
    check_eq("kv_12345_lit", key_value, 32'd12345);
    press(KSTAR, "kv_bksp1");
    check_eq("kv_1234_lit", key_value, 32'd1234);
    for (int i = 0; i < 4; i++) press(KSTAR, $sformatf("kv_bksp%0d", i + 2));
    check_eq("kv_empty_lit", key_value, 32'h00CC_0000);

    // Bounce on key 5, then ghosting of keys 1+2: no press accepted.
    kv_q.push_back(model_kv());
    pressed = 16'd1 << K5; repeat (SWEEP) @(posedge key_clk);
    pressed = 16'd0;       repeat (SWEEP) @(posedge key_clk);
    pressed = 16'd1 << K5; repeat (SWEEP) @(posedge key_clk);
    pressed = 16'd0;       repeat (HOLD) @(posedge key_clk);
    @(negedge key_clk);
    check_eq("kv_bounce", key_value, kv_q.pop_front());
    kv_q.push_back(model_kv());
    pressed = (16'd1 << K1) | (16'd1 << K2); repeat (HOLD) @(posedge key_clk);
    pressed = 16'd0;                         repeat (HOLD) @(posedge key_clk);
    @(negedge key_clk);
    check_eq("kv_ghost", key_value, kv_q.pop_front());

    press(KHASH, "kv_sign_empty");
    press(KD, "kv_after_D");
    press(K0, "kv_zero");
    check_eq("kv_zero_lit", key_value, 32'd0);
    press(KB, "kv_after_B");
    for (int i = 0; i < 5; i++) press(K9, $sformatf("kv_9s%0d", i));
    press(KHASH, "kv_neg99999");
    press(KC, "kv_after_C");

    // Reset while key 7 is held: re-debounced and accepted once after reset.
    pressed = 16'd1 << K7;
    repeat (HOLD) @(posedge key_clk);
    @(negedge key_clk);
    check_eq("kv_7_pre", key_value, 32'd7);
    rst = 1'b1;
    repeat (2) @(posedge key_clk);
    @(negedge key_clk);
    check_eq("rst2_key_value", key_value, 32'h00CC_0000);
    check_eq("rst2_key_col", {28'd0, key_col}, 32'h0000_000E);
    rst = 1'b0;
    model_reset();
    model_key(K7);
    kv_q.push_back(model_kv());
    repeat (2 * SWEEP) @(posedge key_clk);
    @(negedge key_clk);
    check_eq("kv_rst_not_yet", key_value, 32'h00CC_0000);
    @(posedge key_clk);
    @(negedge key_clk);
    check_eq("kv_rst_accept", key_value, 32'd7);
    repeat (HOLD) @(posedge key_clk);
    pressed = 16'd0;
    repeat (HOLD) @(posedge key_clk);
    @(negedge key_clk);
    check_eq("kv_rst_once", key_value, kv_q.pop_front());

    check_eq("op_pulses", 32'(ops_seen), 32'(ops_exp));
    check_eq("op_queue_left", 32'(num_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
